// File: rtl/dram_ctrl.sv
// Data-memory controller: turns level-held processor and host requests into
// timed single-port RAM cycles, each ending in a one-cycle completion pulse.
module dram_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              memREAD,
    input  logic              memWRITE,
    input  logic [ADDR_W-1:0] DRAM_addr,
    input  logic [WIDTH-1:0]  DRAM_dataOut,
    output logic [WIDTH-1:0]  DRAM_dataIn,
    output logic              memDONE,
    input  logic              hostREQ,
    input  logic              hostWE,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [WIDTH-1:0]  hostWData,
    output logic [WIDTH-1:0]  hostRData,
    output logic              hostACK,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [WIDTH-1:0]  ram_rdata,
    output logic              protoErr,
    output logic [2:0]        fsm_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // WAIT lasts RD_LAT-1 cycles: load RD_LAT-2 and leave when the count hits zero.
    localparam int         WAIT_INIT_I = (RD_LAT > 1) ? RD_LAT - 2 : 0;
    localparam logic [1:0] WAIT_INIT   = WAIT_INIT_I[1:0];

    logic [2:0] state;
    logic [1:0] wait_cnt;
    logic       proc_arm;
    logic       host_arm;
    logic       owner_host;
    logic       proc_req;
    logic       host_go;
    logic       proc_go;

    assign proc_req  = memREAD | memWRITE;
    assign fsm_state = state;

    // Host wins over the processor whenever both are armed in IDLE.
    always_comb begin
        host_go = 1'b0;
        proc_go = 1'b0;
        if (state == S_IDLE) begin
            host_go = hostREQ && host_arm;
            proc_go = !host_go && proc_req && proc_arm;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            proc_arm    <= 1'b1;
            host_arm    <= 1'b1;
            owner_host  <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            memDONE     <= 1'b0;
            hostACK     <= 1'b0;
            DRAM_dataIn <= '0;
            hostRData   <= '0;
            protoErr    <= 1'b0;
        end else begin
            ram_we  <= 1'b0;
            ram_re  <= 1'b0;
            memDONE <= 1'b0;
            hostACK <= 1'b0;

            // Re-arm only once the request has been seen low, so a held level is not replayed.
            if (!proc_req) begin
                proc_arm <= 1'b1;
            end
            if (!hostREQ) begin
                host_arm <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (host_go) begin
                        host_arm   <= 1'b0;
                        owner_host <= 1'b1;
                        ram_addr   <= hostAddr;
                        ram_wdata  <= hostWData;
                        if (hostWE) begin
                            state  <= S_WR;
                            ram_we <= 1'b1;
                        end else begin
                            state  <= S_RD;
                            ram_re <= 1'b1;
                        end
                    end else if (proc_go) begin
                        proc_arm   <= 1'b0;
                        owner_host <= 1'b0;
                        ram_addr   <= DRAM_addr;
                        ram_wdata  <= DRAM_dataOut;
                        if (memWRITE) begin
                            state  <= S_WR;
                            ram_we <= 1'b1;
                            if (memREAD) begin
                                protoErr <= 1'b1;
                            end
                        end else begin
                            state  <= S_RD;
                            ram_re <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    state   <= S_DONE;
                    memDONE <= !owner_host;
                    hostACK <= owner_host;
                end
                S_RD: begin
                    if (RD_LAT > 1) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end else begin
                        state <= S_CAP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_CAP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_CAP: begin
                    if (owner_host) begin
                        hostRData <= ram_rdata;
                    end else begin
                        DRAM_dataIn <= ram_rdata;
                    end
                    state   <= S_DONE;
                    memDONE <= !owner_host;
                    hostACK <= owner_host;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
